// File: rtl/fp_pkg.sv
// Purpose  : shared types and IEEE-754 single-precision field constants for the accumulator slice.
// Latency  : n/a (package only).
// Backpres.: n/a (package only).
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
   localparam logic [31:0] FP_POS_ZERO = 32'h00000000;
   localparam int          FP_SIGN_BIT = 31;
   localparam int          FP_EXP_HI   = 30;
   localparam int          FP_EXP_LO   = 23;
   localparam int          FP_MAN_HI   = 22;
   localparam int          FP_MAN_LO   = 0;

   // Exponent all-ones marks Inf or NaN.
   function automatic logic fp_is_special(input logic [31:0] f);
      return f[FP_EXP_HI:FP_EXP_LO] == FP_EXP_MAX;
   endfunction

endpackage

// File: rtl/fp_acc_ctrl.sv
// Purpose  : accumulator sequencing: state register, element counter, first-operand flag, handshake decode.
// Latency  : in_ready/out_valid/busy are registered; DONE is entered the cycle after the last operand handshake.
// Backpres.: operands stall while in_valid is low; DONE holds until out_ready.
//
// Ports: clk, rst_n; start/len (command, IDLE only); in_valid/in_ready (operand handshake);
//        out_ready/out_valid (result handshake); busy; first (next operand bypasses the adder);
//        acc_clr (zero acc/special); acc_wr (load acc with the next value); abort (FP_ACC_ABORT_EN only).
import fp_pkg::*;

module fp_acc_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic             out_ready,
`ifdef FP_ACC_ABORT_EN
   input  logic             abort,
`endif
   output logic             in_ready,
   output logic             out_valid,
   output logic             busy,
   output logic             first,
   output logic             acc_clr,
   output logic             acc_wr
);

   acc_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             abort_hit;
   logic             in_fire;

`ifdef FP_ACC_ABORT_EN
   assign abort_hit = abort && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // An abort swallows a coincident operand handshake.
   assign in_fire = in_valid && in_ready && !abort_hit;
   assign acc_wr  = in_fire;
   assign acc_clr = abort_hit || ((state == IDLE) && start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         first     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (abort_hit) begin
         state     <= IDLE;
         cnt       <= '0;
         first     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len != '0) begin
                     state    <= ACCUM;
                     cnt      <= len;
                     first    <= 1'b1;
                     in_ready <= 1'b1;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (in_fire) begin
                  cnt   <= cnt - 1'b1;
                  first <= 1'b0;
                  if (cnt == CNT_W'(1)) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fp_accumulator.sv
// Purpose  : sums a stream of single-precision operands by looping an external combinational adder.
// Latency  : sum valid 1 cycle after the last operand handshake; 1 operand/cycle throughput.
// Backpres.: in_ready low outside ACCUM; result held in DONE until out_ready.
//
// Ports: start/len command; in_valid/in_ready/in_data/in_sub operand stream;
//        add_a/add_b/add_op/add_result to the external adder (no register in that path);
//        out_valid/out_ready/out_data/out_special result; busy.
// Optional: define FP_ACC_ABORT_EN to add the abort input.
import fp_pkg::*;

module fp_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_sub,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   output logic             add_op,
   input  logic [31:0]      add_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_special,
`ifdef FP_ACC_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy
);

   logic [31:0] acc;
   logic [31:0] acc_next;
   logic        special;
   logic        first;
   logic        acc_clr;
   logic        acc_wr;

   fp_acc_ctrl #(.CNT_W(CNT_W)) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .out_ready (out_ready),
`ifdef FP_ACC_ABORT_EN
      .abort     (abort),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .busy      (busy),
      .first     (first),
      .acc_clr   (acc_clr),
      .acc_wr    (acc_wr)
   );

   assign add_a  = acc;
   assign add_b  = in_data;
   assign add_op = in_sub;

   // The first operand seeds acc directly (sign flipped for subtract) so the adder never sees 0 +/- x.
   assign acc_next = first ? {in_data[FP_SIGN_BIT] ^ in_sub, in_data[FP_EXP_HI:FP_MAN_LO]}
                           : add_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= FP_POS_ZERO;
         special <= 1'b0;
      end else if (acc_clr) begin
         acc     <= FP_POS_ZERO;
         special <= 1'b0;
      end else if (acc_wr) begin
         acc     <= acc_next;
         special <= special | fp_is_special(acc_next);
      end
   end

   // Outputs read as zero whenever no result is being offered.
   assign out_data    = out_valid ? acc : FP_POS_ZERO;
   assign out_special = out_valid & special;

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential reduction stage that sits directly downstream of the combinational 32-bit IEEE-754 add/sub top.
- Consumes that adder's Result and feeds it back as the next NumberA, so a stream of N single-precision operands is summed into one result.
- Upstream operands and the downstream sum each use a valid/ready handshake.
- The adder stays a separate instance. This block drives its NumberA, NumberB and A_S inputs and samples its Result in the same cycle.

Parameters:
- CNT_W, 8, width of the length/element counter (max vector length 2^CNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  CNT_W  number of elements to sum; sampled with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_data  in  32  IEEE-754 single operand.
- in_sub  in  1  1 = subtract this operand, 0 = add.
- add_a  out  32  to adder NumberA; equals acc.
- add_b  out  32  to adder NumberB; equals in_data.
- add_op  out  1  to adder A_S; equals in_sub.
- add_result  in  32  from adder Result, combinational same-cycle.
- out_valid  out  1  sum available.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  32  final sum.
- out_special  out  1  sticky: some intermediate or final acc had exponent 8'hFF (Inf/NaN).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n low) values: state=IDLE, acc=32'h0, cnt=0, first=0, special=0. Outputs in_ready=0, out_valid=0, out_data=0, out_special=0, busy=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: go to ACCUM; cnt<=len, acc<=0, first<=1, special<=0.
  - start=1 and len==0: go to DONE with acc<=32'h00000000 and special<=0.
- ACCUM:
  - in_ready=1 for the whole state.
  - On a handshake with first=1: acc<={in_data[31]^in_sub, in_data[30:0]}, bypassing the adder; first<=0.
  - On a handshake with first=0: acc<=add_result.
  - On every handshake: cnt<=cnt-1; special|=(new acc[30:23]==8'hFF).
  - Handshake with cnt==1: go to DONE next cycle.
- DONE:
  - out_valid=1, out_data=acc, out_special=special; all held stable until out_ready.
  - out_valid && out_ready: go to IDLE, clearing out_valid the next cycle.
- start is ignored outside IDLE.
- in_ready=0 in IDLE and DONE; in_data/in_valid are don't-care there.
- Latency: the sum is valid 1 cycle after the last operand handshake. Back-to-back operands are accepted every cycle, so throughput is 1 operand/cycle.
- add_a, add_b and add_op are purely combinational from acc, in_data and in_sub. No register sits between this block and the adder.
- Rounding, zero and special-case handling are entirely the adder's. This block never alters add_result.
- cnt wrap-around cannot occur because the decrement happens only while cnt>=1.
- rst_n asserted mid-ACCUM or mid-DONE: immediate return to reset values. The partial sum is discarded, with no out_valid pulse.

Optional Feature:
- Macro: FP_ACC_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in ACCUM or DONE: go to IDLE next cycle, acc<=0, special<=0, no out_valid.
  - abort has priority over a coincident operand or output handshake; that handshake does not update acc.
  - abort in IDLE is ignored.
- When undefined: the port is absent and the behaviour is exactly as above.

Decomposition:
- Shared package fp_pkg holds:
  - state enum {IDLE, ACCUM, DONE};
  - FP_EXP_MAX=8'hFF;
  - FP_POS_ZERO=32'h00000000;
  - FP_SIGN_BIT=31;
  - the float field-slice constants (sign/exp/mantissa bounds).
- One natural sub-module: fp_acc_ctrl (state register, cnt, first flag, handshake decode). The acc/special datapath stays in the parent.

Test Plan:
- len=3, operands 3F800000, 40000000, 40400000, all add, in_valid held high → accepted on 3 consecutive cycles; out_valid 1 cycle later; out_data=40C00000 (6.0); out_special=0.
- len=2, first operand 3F800000 with in_sub=1, then 40000000 add → first acc=BF800000; out_data=3F800000 (1.0).
- start with len=0 → next cycle DONE; out_valid=1, out_data=00000000; in_ready never asserted.
- len=2, operands 7F800000 then 3F800000 → out_special=1; out_data exponent=FF.
- len=1, out_ready low for 5 cycles after out_valid → out_data and out_valid stable for all 5 cycles; one cycle after out_ready=1, state is IDLE and busy=0.
- len=4, rst_n pulsed low after the 2nd operand → all outputs at reset values; a subsequent start with len=1 and 40400000 yields out_data=40400000.
